// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU definitions: finv latency, in-flight tracking
//               entry and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // Latency of the finv pipeline, in clock edges from operand to result.
  localparam int FINV_LAT  = 3;
  // Upper bound on requesters sharing one FPU unit; sizes the tag field.
  localparam int N_REQ_MAX = 16;
  localparam int ID_W_MAX  = $clog2(N_REQ_MAX);

  // One tracking entry travelling alongside an operand in the pipeline.
  typedef struct packed {
    logic                v;
    logic [ID_W_MAX-1:0] id;
  } inflight_t;

  // Decode a requester tag into a one-hot vector of N_REQ_MAX bits.
  function automatic logic [N_REQ_MAX-1:0] onehot_dec(input logic [ID_W_MAX-1:0] idx);
    logic [N_REQ_MAX-1:0] dec;
    dec      = '0;
    dec[idx] = 1'b1;
    return dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Search starts one past
//               the pointer and wraps; first asserted request wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Priority search over the rotated request vector.
  always_comb begin
    int j;
    j         = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt[j]    = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/finv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : finv_arbiter
// Description : Shares one fixed-latency finv pipeline between N_REQ
//               requesters. Round-robin issue, tag tracking alongside the
//               pipeline, one-cycle result pulse back to the requester.
//               Optional macro FINV_ARB_STATS_EN adds issue/conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module finv_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = FINV_LAT,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [32*N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [31:0]              finv_x,
  input  logic [31:0]              finv_y,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [31:0]              resp_y,
`ifdef FINV_ARB_STATS_EN
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_conflict,
`endif
  output logic                     busy,
  output logic [$clog2(LAT+1)-1:0] inflight
);

  localparam int c_CNT_W = $clog2(LAT+1);
  localparam int c_LAST  = LAT - 1;

  logic [N_REQ-1:0]     w_gnt;
  logic [ID_W-1:0]      w_gnt_idx;
  logic                 w_xfer;
  logic [ID_W-1:0]      r_rr_ptr;
  inflight_t            r_pipe [LAT];
  inflight_t            w_last;
  logic [N_REQ_MAX-1:0] w_dec;
  logic [c_CNT_W-1:0]   w_cnt;
  logic                 w_any_v;
  logic                 w_unused;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .gnt       (w_gnt),
    .gnt_idx   (w_gnt_idx),
    .gnt_valid (w_xfer)
  );

  assign req_ready = w_gnt;

  // Steer the granted operand onto the shared pipeline input.
  always_comb begin
    finv_x = 32'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) finv_x = req_x[32*i +: 32];
    end
  end

  // Pointer remembers the last winner; reset value gives requester 0 priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_rr_ptr <= ID_W'(N_REQ-1);
    else if (w_xfer) r_rr_ptr <= w_gnt_idx;
  end

  // Tag shift register mirroring the finv pipeline stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_xfer, ID_W_MAX'(w_gnt_idx)};
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_last     = r_pipe[c_LAST];
  assign w_dec      = onehot_dec(w_last.id);
  assign resp_valid = w_last.v ? w_dec[N_REQ-1:0] : '0;
  assign resp_id    = w_last.v ? w_last.id[ID_W-1:0] : '0;
  assign resp_y     = finv_y;

  // Occupancy: popcount and OR of the stage valid bits.
  always_comb begin
    w_cnt   = '0;
    w_any_v = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      w_cnt   = w_cnt + c_CNT_W'(r_pipe[i].v);
      w_any_v = w_any_v | r_pipe[i].v;
    end
  end

  assign inflight = w_cnt;
  assign busy     = w_any_v;

  // Tag and decode bits beyond N_REQ/ID_W exist only for package sizing.
  assign w_unused = ^{w_dec, w_last.id};

`ifdef FINV_ARB_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_conflict;
  logic        w_multi;

  // Two or more requests pending: clearing the lowest set bit leaves something.
  assign w_multi = |(req_valid & (req_valid - N_REQ'(1)));

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_issued   <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_xfer)  r_stat_issued   <= r_stat_issued + 32'd1;
      if (w_multi) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign stat_issued   = r_stat_issued;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_finv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_finv_arbiter
// Description : Directed self-checking bench for finv_arbiter with a
//               3-stage reciprocal model standing in for finv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_finv_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 3;
  localparam int ID_W  = 2;
  localparam int CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N_REQ-1:0]     req_valid;
  logic [32*N_REQ-1:0]  req_x;
  logic [N_REQ-1:0]     req_ready;
  logic [31:0]          finv_x;
  logic [31:0]          finv_y;
  logic [N_REQ-1:0]     resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [31:0]          resp_y;
  logic                 busy;
  logic [CNT_W-1:0]     inflight;
`ifdef FINV_ARB_STATS_EN
  logic [31:0]          stat_issued;
  logic [31:0]          stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] xv [4] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F000000};
  logic [31:0] yv [4] = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h40000000};

  logic [31:0] fy0 = '0, fy1 = '0, fy2 = '0;

  finv_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_ready     (req_ready),
    .finv_x        (finv_x),
    .finv_y        (finv_y),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_y        (resp_y),
`ifdef FINV_ARB_STATS_EN
    .stat_issued   (stat_issued),
    .stat_conflict (stat_conflict),
`endif
    .busy          (busy),
    .inflight      (inflight)
  );

  always #5 clk = ~clk;

  // Reciprocal lookup for the operands used here.
  function automatic logic [31:0] recip(input logic [31:0] x);
    case (x)
      32'h3F800000: return 32'h3F800000;
      32'h40000000: return 32'h3F000000;
      32'h40800000: return 32'h3E800000;
      32'h3F000000: return 32'h40000000;
      default:      return x ^ 32'hDEAD0000;
    endcase
  endfunction

  // Three-edge finv model, no reset so stale results keep flowing.
  always @(posedge clk) begin
    fy0 <= recip(finv_x);
    fy1 <= fy0;
    fy2 <= fy1;
  end
  assign finv_y = fy2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Operands in flight after edge c when n back-to-back issues start at edge first.
  function automatic int exp_inflight(input int c, input int first, input int n);
    int cnt = 0;
    for (int e = first; e < first + n; e++)
      if (c >= e && c <= e + LAT - 1) cnt++;
    return cnt;
  endfunction

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_x     = '0;
    tick();
    tick();
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id",    32'(resp_id),    32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_inflight",   32'(inflight),   32'h0);
    check("rst_ready",      32'(req_ready),  32'h0);
    check("rst_finv_x",     finv_x,          32'h0);
    rstn = 1'b1;

    // Single issue from requester 0.
    for (int i = 0; i < N_REQ; i++) req_x[32*i +: 32] = xv[i];
    req_x[31:0] = 32'h40000000;
    req_valid   = 4'b0001;
    #1;
    check("t1_ready",  32'(req_ready), 32'h1);
    check("t1_finv_x", finv_x,         32'h40000000);
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      check("t1_resp_valid", 32'(resp_valid), (c == 2) ? 32'h1 : 32'h0);
      check("t1_busy",       32'(busy),       (c < 3) ? 32'h1 : 32'h0);
      if (c == 2) begin
        check("t1_resp_id", 32'(resp_id), 32'h0);
        check("t1_resp_y",  resp_y,       32'h3F000000);
      end
      tick();
    end

    // Full contention, each requester drops after its grant.
    do_reset();
    req_x[31:0] = xv[0];
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 4) ? 4'((4'hF << c) & 4'hF) : 4'h0;
      #1;
      check("t2_ready",  32'(req_ready), (c < 4) ? (32'h1 << c) : 32'h0);
      check("t2_finv_x", finv_x,         (c < 4) ? xv[c] : 32'h0);
      tick();
      check("t2_inflight", 32'(inflight), 32'(exp_inflight(c, 0, 4)));
      if (c >= 2 && c <= 5) begin
        check("t2_resp_valid", 32'(resp_valid), 32'h1 << (c - 2));
        check("t2_resp_id",    32'(resp_id),    32'(c - 2));
        check("t2_resp_y",     resp_y,          yv[c-2]);
      end else begin
        check("t2_resp_idle", 32'(resp_valid), 32'h0);
        check("t2_id_idle",   32'(resp_id),    32'h0);
      end
    end
`ifdef FINV_ARB_STATS_EN
    check("stat_issued",   stat_issued,   32'd4);
    check("stat_conflict", stat_conflict, 32'd3);
`endif

    // Requester 2 alone for 8 back-to-back cycles.
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'b0100 : 4'b0000;
      #1;
      check("t3_ready", 32'(req_ready), (c < 8) ? 32'h4 : 32'h0);
      tick();
      check("t3_inflight", 32'(inflight), 32'(exp_inflight(c, 0, 8)));
      if (c >= 2 && c <= 9) begin
        check("t3_resp_valid", 32'(resp_valid), 32'h4);
        check("t3_resp_id",    32'(resp_id),    32'h2);
        check("t3_resp_y",     resp_y,          32'h3E800000);
      end else begin
        check("t3_resp_idle", 32'(resp_valid), 32'h0);
      end
    end

    // Reset while two operands are in flight.
    req_valid = 4'b0010;
    tick();
    tick();
    check("t4_pre_inflight", 32'(inflight), 32'h2);
    rstn = 1'b0;
    #1;
    check("t4_busy",     32'(busy),       32'h0);
    check("t4_inflight", 32'(inflight),   32'h0);
    check("t4_resp",     32'(resp_valid), 32'h0);
    tick();
    rstn      = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_no_resp", 32'(resp_valid), 32'h0);
      check("t4_idle",    32'(busy),       32'h0);
    end
    req_valid = 4'b1111;
    #1;
    check("t4_ptr_restored", 32'(req_ready), 32'h1);

    // Withdrawal: requester 1 leaves before being granted.
    req_valid = 4'b0011;
    #1;
    check("t5_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t5_no_ready", 32'(req_ready), 32'h0);
    check("t5_finv_x0",  finv_x,         32'h0);
    tick();
    req_valid = 4'b1111;
    #1;
    check("t5_ptr_held", 32'(req_ready), 32'h2);
    req_valid = 4'b0101;
    #1;
    check("t5_skip", 32'(req_ready), 32'h4);
    req_valid = 4'b0001;
    #1;
    check("t5_wrap", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
